// File: rtl/media_fetch_pkg.sv
// Shared types and constants for the Bad Apple SD-card fetch scheduler.
package media_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REQ,
    WAIT,
    FIN
  } fetch_state_e;

  localparam logic SRC_VIDEO = 1'b0;
  localparam logic SRC_AUDIO = 1'b1;

  localparam int unsigned SECTOR_BYTES         = 512;
  localparam int unsigned DEF_AUDIO_LOW_WATER  = 256;
  localparam int unsigned DEF_AUDIO_HIGH_WATER = 1536;

endpackage

// File: rtl/media_fetch_sched_if.sv
// Block-read handshake between the fetch scheduler (master) and the SPI read engine (slave).
interface media_fetch_sched_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_src;
  logic        rd_ack;
  logic        rd_done;

  modport master (output rd_req, rd_addr, rd_src, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_src, output rd_ack, rd_done);
endinterface

// File: rtl/fetch_watchdog.sv
// Counts enabled cycles and pulses expired on the TIMEOUT_CYCLES-th one; clear restarts the count.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the limit so a stuck enable cannot produce a second pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/media_fetch_sched.sv
// Arbitrates the shared SPI block-read engine between the audio FIFO and the video frame buffer.
module media_fetch_sched
  import media_fetch_pkg::*;
#(
  parameter logic [31:0] VIDEO_BASE_SECTOR = 32'h0000_0800,
  parameter logic [31:0] AUDIO_BASE_SECTOR = 32'h0010_0000,
  parameter int unsigned SECTORS_PER_FRAME = 75,
  parameter int unsigned NUM_FRAMES        = 6572,
  parameter int unsigned AUDIO_SECTORS     = 16384,
  parameter int unsigned AUD_LVL_W         = 11,
  parameter int unsigned AUDIO_LOW_WATER   = DEF_AUDIO_LOW_WATER,
  parameter int unsigned AUDIO_HIGH_WATER  = DEF_AUDIO_HIGH_WATER,
  parameter int unsigned TIMEOUT_CYCLES    = 4_000_000
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AUD_LVL_W-1:0] audio_level,
  input  logic                 video_need,
  media_fetch_sched_if.master  rd_bus,
  output logic                 play_active,
  output logic                 frame_done,
  output logic [12:0]          frame_idx,
  output logic                 fetch_err
);

  localparam int unsigned FS_W = (SECTORS_PER_FRAME > 1) ? $clog2(SECTORS_PER_FRAME) : 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      vid_cnt_q, vid_cnt_d;
  logic [31:0]      aud_cnt_q, aud_cnt_d;
  logic [FS_W-1:0]  frame_sec_q, frame_sec_d;
  logic [12:0]      frame_idx_q, frame_idx_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic             rd_req_q, rd_req_d;
  logic             rd_src_q, rd_src_d;
  logic             play_active_q, play_active_d;
  logic             frame_done_q, frame_done_d;
  logic             fetch_err_q, fetch_err_d;

  logic aud_left, vid_left;
  logic grant, grant_src, complete;
  logic wd_expired;

  assign aud_left = (aud_cnt_q != AUDIO_SECTORS);
  assign vid_left = (frame_idx_q != 13'(NUM_FRAMES));

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK_40),
    .rst    (reset),
    .clear  (state_q != WAIT),
    .enable (state_q == WAIT),
    .expired(wd_expired)
  );

  // Urgent audio beats video, which beats opportunistic audio top-up.
  always_comb begin
    grant     = 1'b0;
    grant_src = SRC_VIDEO;
    if (aud_left && (audio_level < AUD_LVL_W'(AUDIO_LOW_WATER))) begin
      grant     = 1'b1;
      grant_src = SRC_AUDIO;
    end else if (vid_left && video_need) begin
      grant     = 1'b1;
      grant_src = SRC_VIDEO;
    end else if (aud_left && (audio_level < AUD_LVL_W'(AUDIO_HIGH_WATER))) begin
      grant     = 1'b1;
      grant_src = SRC_AUDIO;
    end
  end

  always_comb begin
    state_d       = state_q;
    vid_cnt_d     = vid_cnt_q;
    aud_cnt_d     = aud_cnt_q;
    frame_sec_d   = frame_sec_q;
    frame_idx_d   = frame_idx_q;
    rd_addr_d     = rd_addr_q;
    rd_req_d      = rd_req_q;
    rd_src_d      = rd_src_q;
    play_active_d = play_active_q;
    frame_done_d  = 1'b0;
    fetch_err_d   = fetch_err_q;
    complete      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ARB;
          play_active_d = 1'b1;
          vid_cnt_d     = '0;
          aud_cnt_d     = '0;
          frame_sec_d   = '0;
          frame_idx_d   = '0;
        end
      end
      ARB: begin
        if (!aud_left && !vid_left) begin
          state_d = FIN;
        end else if (grant) begin
          state_d   = REQ;
          rd_req_d  = 1'b1;
          rd_src_d  = grant_src;
          rd_addr_d = (grant_src == SRC_AUDIO) ? AUDIO_BASE_SECTOR + aud_cnt_q
                                               : VIDEO_BASE_SECTOR + vid_cnt_q;
        end
      end
      REQ: begin
        if (rd_bus.rd_ack) begin
          rd_req_d = 1'b0;
          if (rd_bus.rd_done) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rd_bus.rd_done) begin
          complete = 1'b1;
        end else if (wd_expired) begin
          fetch_err_d = 1'b1;
          state_d     = ARB;
        end
      end
      FIN: begin
        play_active_d = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A timed-out sector skips this path, so the next grant re-reads it.
    if (complete) begin
      state_d = ARB;
      if (rd_src_q == SRC_AUDIO) begin
        aud_cnt_d = aud_cnt_q + 32'd1;
      end else begin
        vid_cnt_d = vid_cnt_q + 32'd1;
        if (frame_sec_q == FS_W'(SECTORS_PER_FRAME - 1)) begin
          frame_sec_d  = '0;
          frame_idx_d  = frame_idx_q + 13'd1;
          frame_done_d = 1'b1;
        end else begin
          frame_sec_d = frame_sec_q + FS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vid_cnt_q     <= '0;
      aud_cnt_q     <= '0;
      frame_sec_q   <= '0;
      frame_idx_q   <= '0;
      rd_addr_q     <= '0;
      rd_req_q      <= 1'b0;
      rd_src_q      <= 1'b0;
      play_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vid_cnt_q     <= vid_cnt_d;
      aud_cnt_q     <= aud_cnt_d;
      frame_sec_q   <= frame_sec_d;
      frame_idx_q   <= frame_idx_d;
      rd_addr_q     <= rd_addr_d;
      rd_req_q      <= rd_req_d;
      rd_src_q      <= rd_src_d;
      play_active_q <= play_active_d;
      frame_done_q  <= frame_done_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = rd_addr_q;
  assign rd_bus.rd_src  = rd_src_q;
  assign play_active    = play_active_q;
  assign frame_done     = frame_done_q;
  assign frame_idx      = frame_idx_q;
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_media_fetch_sched.sv
// Self-checking bench for media_fetch_sched: priority table, frame/timeout/exhaust sequences, randomized reads.
module tb_media_fetch_sched;
  import media_fetch_pkg::*;

  localparam int SPF = 75;
  localparam int NF  = 2;
  localparam int AS  = 12;
  localparam int TO  = 50;
  localparam logic [31:0] VBASE = 32'h0000_0800;
  localparam logic [31:0] ABASE = 32'h0010_0000;

  logic        CLK_40 = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] audio_level;
  logic        video_need;
  logic        play_active;
  logic        frame_done;
  logic [12:0] frame_idx;
  logic        fetch_err;

  media_fetch_sched_if bus();

  media_fetch_sched #(
    .SECTORS_PER_FRAME(SPF),
    .NUM_FRAMES       (NF),
    .AUDIO_SECTORS    (AS),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .CLK_40     (CLK_40),
    .reset      (reset),
    .start      (start),
    .audio_level(audio_level),
    .video_need (video_need),
    .rd_bus     (bus),
    .play_active(play_active),
    .frame_done (frame_done),
    .frame_idx  (frame_idx),
    .fetch_err  (fetch_err)
  );

  always #5 CLK_40 = ~CLK_40;

  typedef struct {
    logic [10:0] lvl;
    logic        need;
    logic        src;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;
  int mVid  = 0;
  int mAud  = 0;
  int vidGrants = 0;
  int audGrants = 0;
  int bytesMoved = 0;
  logic reqPrev = 1'b0;

  // Independent count of grants seen on the bus (rising edges of rd_req).
  always @(negedge CLK_40) begin
    if (bus.rd_req === 1'b1 && reqPrev !== 1'b1) begin
      if (bus.rd_src === SRC_AUDIO) audGrants++;
      else vidGrants++;
    end
    reqPrev = bus.rd_req;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] lvl, input logic need);
    audio_level = lvl;
    video_need  = need;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge CLK_40);
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_rd_req"},      32'(bus.rd_req),      32'd0);
    checkOutput({pfx, "_rd_addr"},     bus.rd_addr,          32'd0);
    checkOutput({pfx, "_rd_src"},      32'(bus.rd_src),      32'd0);
    checkOutput({pfx, "_play_active"}, 32'(play_active),     32'd0);
    checkOutput({pfx, "_frame_done"},  32'(frame_done),      32'd0);
    checkOutput({pfx, "_frame_idx"},   32'(frame_idx),       32'd0);
    checkOutput({pfx, "_fetch_err"},   32'(fetch_err),       32'd0);
  endtask

  task automatic waitReq(input string name, output bit ok);
    int waited = 0;
    while (bus.rd_req !== 1'b1 && waited < 64) begin
      @(negedge CLK_40);
      waited++;
    end
    ok = (bus.rd_req === 1'b1);
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_grant: rd_req low for %0d cycles, required a grant", name, waited);
    end
  endtask

  // Engine model: accept after ackDly cycles, deliver doneDly cycles after the ack (0 = same cycle).
  task automatic serveRead(input string name, input int ackDly, input int doneDly,
                           input logic expSrc, input logic [31:0] expAddr);
    bit ok;
    waitReq(name, ok);
    if (!ok) return;
    checkOutput({name, "_src"},  32'(bus.rd_src), 32'(expSrc));
    checkOutput({name, "_addr"}, bus.rd_addr,     expAddr);
    repeat (ackDly) @(negedge CLK_40);
    checkOutput({name, "_addr_hold"}, bus.rd_addr, expAddr);
    bus.rd_ack  = 1'b1;
    bus.rd_done = (doneDly == 0);
    @(negedge CLK_40);
    bus.rd_ack  = 1'b0;
    bus.rd_done = 1'b0;
    if (doneDly > 0) begin
      repeat (doneDly - 1) @(negedge CLK_40);
      bus.rd_done = 1'b1;
      @(negedge CLK_40);
      bus.rd_done = 1'b0;
    end
    if (expSrc == SRC_AUDIO) mAud++;
    else mVid++;
    bytesMoved += SECTOR_BYTES;
    checkOutput({name, "_frame_done"}, 32'(frame_done),
                32'((expSrc == SRC_VIDEO) && (mVid % SPF == 0)));
    checkOutput({name, "_frame_idx"}, 32'(frame_idx), 32'(mVid / SPF));
    checkOutput({name, "_req_low"},   32'(bus.rd_req), 32'd0);
  endtask

  // Reference arbitration computed from the water-mark rules and remaining-sector counts.
  function automatic void predict(input logic [10:0] lvl, input logic need,
                                  output logic g, output logic s, output logic [31:0] a);
    bit audLeft;
    bit vidLeft;
    audLeft = (mAud < AS);
    vidLeft = (mVid < NF * SPF);
    g = 1'b1;
    s = SRC_VIDEO;
    if (audLeft && lvl < 11'd256)       s = SRC_AUDIO;
    else if (vidLeft && need)           s = SRC_VIDEO;
    else if (audLeft && lvl < 11'd1536) s = SRC_AUDIO;
    else                                g = 1'b0;
    a = (s == SRC_AUDIO) ? ABASE + 32'(mAud) : VBASE + 32'(mVid);
  endfunction

  initial begin
    bit          ok;
    logic        g;
    logic        s;
    logic [31:0] a;
    logic [10:0] lvl;
    logic        need;
    int          iter;

    vecs[0] = '{11'd100,  1'b1, SRC_AUDIO, 32'h0010_0000};
    vecs[1] = '{11'd1000, 1'b1, SRC_VIDEO, 32'h0000_084B};
    vecs[2] = '{11'd1000, 1'b0, SRC_AUDIO, 32'h0010_0001};
    vecs[3] = '{11'd255,  1'b0, SRC_AUDIO, 32'h0010_0002};
    vecs[4] = '{11'd256,  1'b1, SRC_VIDEO, 32'h0000_084C};
    vecs[5] = '{11'd1535, 1'b0, SRC_AUDIO, 32'h0010_0003};
    vecs[6] = '{11'd0,    1'b1, SRC_AUDIO, 32'h0010_0004};
    vecs[7] = '{11'd1536, 1'b1, SRC_VIDEO, 32'h0000_084D};

    reset = 1'b1;
    start = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.rd_done = 1'b0;
    applyStimulus(11'd0, 1'b0);
    repeat (2) @(negedge CLK_40);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge CLK_40);

    $display("[TB] first frame of video");
    applyStimulus(11'd2000, 1'b1);
    pulseStart();
    checkOutput("start_play_active", 32'(play_active), 32'd1);
    for (int i = 0; i < SPF; i++) begin
      serveRead("frame0", 3, 20, SRC_VIDEO, VBASE + 32'(mVid));
    end
    applyStimulus(11'd2000, 1'b0);
    @(negedge CLK_40);
    checkOutput("frame_done_single", 32'(frame_done), 32'd0);
    checkOutput("frame_idx_one",     32'(frame_idx),  32'd1);
    pulseStart();
    repeat (3) @(negedge CLK_40);
    checkOutput("arb_hold_no_req",  32'(bus.rd_req),  32'd0);
    checkOutput("arb_hold_playing", 32'(play_active), 32'd1);

    $display("[TB] priority table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].lvl, vecs[i].need);
      serveRead($sformatf("vec%0d", i), 1, 2, vecs[i].src, vecs[i].addr);
    end
    applyStimulus(11'd1536, 1'b0);
    repeat (4) @(negedge CLK_40);
    checkOutput("hi_water_hold", 32'(bus.rd_req), 32'd0);

    $display("[TB] ack and done together");
    applyStimulus(11'd1000, 1'b1);
    serveRead("ackdone",       0, 0, SRC_VIDEO, 32'h0000_084E);
    serveRead("after_ackdone", 1, 2, SRC_VIDEO, 32'h0000_084F);

    $display("[TB] watchdog");
    serveRead("done_at_limit", 0, TO, SRC_VIDEO, 32'h0000_0850);
    checkOutput("no_err_at_limit", 32'(fetch_err), 32'd0);
    waitReq("timeout", ok);
    if (ok) begin
      checkOutput("timeout_addr", bus.rd_addr, 32'h0000_0851);
      bus.rd_ack = 1'b1;
      @(negedge CLK_40);
      bus.rd_ack = 1'b0;
      repeat (TO - 1) @(negedge CLK_40);
      checkOutput("timeout_err_early", 32'(fetch_err), 32'd0);
      @(negedge CLK_40);
      checkOutput("timeout_err_set",   32'(fetch_err), 32'd1);
    end
    serveRead("retry", 0, 3, SRC_VIDEO, 32'h0000_0851);
    checkOutput("err_sticky", 32'(fetch_err), 32'd1);

    $display("[TB] randomized reads to end of stream");
    iter = 0;
    while ((mVid < NF * SPF || mAud < AS) && iter < 1000) begin
      iter++;
      lvl  = 11'($urandom_range(2047, 0));
      need = ($urandom_range(3, 0) != 0);
      applyStimulus(lvl, need);
      predict(lvl, need, g, s, a);
      if (g) begin
        serveRead("rand", int'($urandom_range(4, 0)), int'($urandom_range(6, 0)), s, a);
      end else begin
        repeat (4) @(negedge CLK_40);
        checkOutput("rand_idle", 32'(bus.rd_req), 32'd0);
      end
    end
    if (iter >= 1000) begin
      total++;
      bad++;
      $display("[TB] FAIL rand_progress: %0d video %0d audio after %0d tries, required %0d/%0d",
               mVid, mAud, iter, NF * SPF, AS);
    end

    applyStimulus(11'd0, 1'b1);
    @(negedge CLK_40);
    checkOutput("fin_still_active", 32'(play_active), 32'd1);
    @(negedge CLK_40);
    checkOutput("play_fall", 32'(play_active), 32'd0);
    repeat (5) @(negedge CLK_40);
    checkOutput("exhaust_no_req", 32'(bus.rd_req), 32'd0);
    checkOutput("video_grants",   32'(vidGrants), 32'(NF * SPF + 1));
    checkOutput("audio_grants",   32'(audGrants), 32'(AS));

    $display("[TB] restart after end of stream");
    mVid = 0;
    mAud = 0;
    applyStimulus(11'd2000, 1'b1);
    pulseStart();
    checkOutput("restart_play",      32'(play_active), 32'd1);
    checkOutput("restart_err_keeps", 32'(fetch_err),   32'd1);
    serveRead("restart", 1, 2, SRC_VIDEO, 32'h0000_0800);

    $display("[TB] reset during WAIT");
    waitReq("rst_wait", ok);
    if (ok) begin
      checkOutput("rst_wait_addr", bus.rd_addr, 32'h0000_0801);
      bus.rd_ack = 1'b1;
      @(negedge CLK_40);
      bus.rd_ack = 1'b0;
      repeat (3) @(negedge CLK_40);
    end
    #2 reset = 1'b1;
    #1 checkAllZero("wait_rst");
    @(negedge CLK_40);
    reset = 1'b0;
    mVid = 0;
    mAud = 0;
    @(negedge CLK_40);
    pulseStart();
    serveRead("post_rst", 1, 2, SRC_VIDEO, 32'h0000_0800);

    $display("[TB] %0d bytes moved through the bench engine", bytesMoved);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
